// File: rtl/scaled_image_pkg.sv
// scaled_image_pkg: shared types, constants and fade helpers for the scaled image renderer
package scaled_image_pkg;
  typedef enum logic [1:0] {IDLE, FADE_IN, SHOWN, FADE_OUT} fade_state_t;
  localparam logic [4:0] FADE_MAX = 5'd16;
  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb4_t;
  function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [4:0] lvl);
    return 4'((8'(c) * 8'(lvl)) >> 4);
  endfunction
  function automatic rgb4_t fade_rgb(input rgb4_t c, input logic [4:0] lvl);
    return rgb4_t'{fade_ch(c.red, lvl), fade_ch(c.green, lvl), fade_ch(c.blue, lvl)};
  endfunction
endpackage

// File: rtl/scale_accum.sv
// scale_accum: incremental floor(n*SRC/DST) coordinate, valid in the same cycle as clear/step
module scale_accum #(
  parameter int SRC = 468,
  parameter int DST = 640,
  parameter int CW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] coord,
  output logic          inc
);
  localparam int AW = $clog2(SRC + DST + 1);
  logic [AW-1:0] acc, sum, acc_next;
  logic [CW-1:0] coord_q;
  logic          wrap;
  // next accumulator and coordinate; SRC<=DST so one subtraction always suffices
  always_comb begin
    sum      = acc + AW'(SRC);
    wrap     = sum >= AW'(DST);
    inc      = !clear && step && wrap;
    acc_next = clear ? '0 : !step ? acc : wrap ? sum - AW'(DST) : sum;
    coord    = clear ? '0 : coord_q + CW'(inc);
  end
  // hold the remainder and the coordinate it belongs to
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc     <= '0;
      coord_q <= '0;
    end else begin
      acc     <= acc_next;
      coord_q <= coord;
    end
endmodule

// File: rtl/scaled_image_renderer.sv
// scaled_image_renderer: stretches an indexed image over the screen with frame-synchronous fading.
// Optional macro SCALED_IMAGE_TRANSPARENT_EN: palette index 0 shows bg_* unfaded.
module scaled_image_renderer
  import scaled_image_pkg::*;
#(
  parameter int IMG_W     = 468,
  parameter int IMG_H     = 468,
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480,
  parameter int IDX_W     = 1,
  parameter int ROM_LAT   = 1,
  parameter int FADE_STEP = 4,
  parameter int ADDR_W    = $clog2(IMG_W * IMG_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              show,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [4:0]        fade_level,
  output logic              shown
);
  localparam int FW = $clog2(FADE_STEP + 1);
  logic              line_start, row_clear, frame_tick, step_en, row_inc, col_inc_unused;
  logic [9:0]        col, row_idx_unused;
  logic [ADDR_W-1:0] base_q, base;
  logic [ROM_LAT:0]  blank_sr;
  logic [FW-1:0]     frame_cnt;
  fade_state_t       state;
  rgb4_t             pal, out_c;
  assign line_start = DrawX == 10'd0;
  assign row_clear  = DrawY == 10'd0;
  assign frame_tick = line_start && row_clear;
  assign step_en    = frame_tick && frame_cnt == FW'(FADE_STEP - 1);
  assign pal_index  = rom_q;
  assign pal        = rgb4_t'{pal_red, pal_green, pal_blue};
  scale_accum #(.SRC(IMG_W), .DST(SCR_W), .CW(10)) u_x (
    .clk(vga_clk), .rst(reset), .clear(line_start), .step(1'b1),
    .coord(col), .inc(col_inc_unused)
  );
  scale_accum #(.SRC(IMG_H), .DST(SCR_H), .CW(10)) u_y (
    .clk(vga_clk), .rst(reset), .clear(row_clear), .step(line_start),
    .coord(row_idx_unused), .inc(row_inc)
  );
  // row_base follows row*IMG_W in step with the row accumulator
  always_comb base = row_clear ? '0 : row_inc ? base_q + ADDR_W'(IMG_W) : base_q;
`ifdef SCALED_IMAGE_TRANSPARENT_EN
  // index 0 lets the background through unfaded; rom_q is already aligned with the delayed blank
  always_comb out_c = !blank_sr[ROM_LAT] ? '0 : rom_q == '0 ? rgb4_t'{bg_red, bg_green, bg_blue} : fade_rgb(pal, fade_level);
`else
  logic unused_bg;
  assign unused_bg = ^{bg_red, bg_green, bg_blue};
  // faded palette colour, forced black outside the visible area
  always_comb out_c = blank_sr[ROM_LAT] ? fade_rgb(pal, fade_level) : '0;
`endif
  // address, blank delay line and colour output registers
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      base_q             <= '0;
      rom_addr           <= '0;
      blank_sr           <= '0;
      {red, green, blue} <= '0;
    end else begin
      base_q             <= base;
      rom_addr           <= base + ADDR_W'(col);
      blank_sr           <= {blank_sr[ROM_LAT-1:0], blank};
      {red, green, blue} <= out_c;
    end
  // frames per fade step; a step is enabled on the tick that wraps the count
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= step_en ? '0 : frame_cnt + FW'(1);
  // fade state machine, acting only on step-enabled frame ticks so changes never tear
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      fade_level <= '0;
      shown      <= 1'b0;
    end else if (step_en) begin
      case (state)
        IDLE:
          if (show) begin
            state      <= FADE_IN;
            fade_level <= 5'd1;
          end
        FADE_IN:
          if (!show) state <= FADE_OUT;
          else if (fade_level == FADE_MAX) state <= SHOWN;
          else begin
            fade_level <= fade_level + 5'd1;
            shown      <= fade_level == FADE_MAX - 5'd1;
            if (fade_level == FADE_MAX - 5'd1) state <= SHOWN;
          end
        SHOWN:
          if (!show) state <= FADE_OUT;
        FADE_OUT:
          if (show) state <= FADE_IN;
          else if (fade_level == 5'd0) state <= IDLE;
          else begin
            fade_level <= fade_level - 5'd1;
            shown      <= 1'b0;
            if (fade_level == 5'd1) state <= IDLE;
          end
      endcase
    end
endmodule
